// File: rtl/fifo_p_depth.sv
// fifo_p_depth: parametrised PipeIn-to-PipeIn FIFO with optional same-cycle
// bypass when empty. Pointers carry an extra wrap bit so that full and empty
// can be told apart. Occupancy and almost_full depend only on registered
// pointers.
module fifo_p_depth #(
  parameter int width  = 32,
  parameter int depth  = 4,
  parameter int afull  = 3,
  parameter int bypass = 0
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     in_enq__ENA,
  input  logic [width-1:0]         in_enq_v,
  output logic                     in_enq__RDY,
  output logic                     out_enq__ENA,
  output logic [width-1:0]         out_enq_v,
  input  logic                     out_enq__RDY,
  output logic [$clog2(depth):0]   count,
  output logic                     almost_full
);

  localparam int aw = $clog2(depth);
  localparam logic [aw:0] ptr_one = (aw+1)'(1);
  localparam logic [aw:0] afull_c = (aw+1)'(afull);
  localparam logic        byp_en  = (bypass != 0);

  logic [width-1:0] mem [depth];
  logic [aw:0]      wr_ptr;
  logic [aw:0]      rd_ptr;
  logic             empty;
  logic             full;
  logic             push;
  logic             byp_beat;
  logic             wr_mem;
  logic             rd_mem;

  // Status, handshake and output data decode from pointers and inputs.
  // A bypassed beat goes straight out and is only stored when the
  // downstream stalls.
  always_comb begin
    empty        = (wr_ptr == rd_ptr);
    full         = (wr_ptr[aw-1:0] == rd_ptr[aw-1:0]) && (wr_ptr[aw] != rd_ptr[aw]);
    in_enq__RDY  = nRST & ~full;
    push         = in_enq__ENA & in_enq__RDY;
    byp_beat     = byp_en & empty & push;
    out_enq__ENA = out_enq__RDY & (~empty | byp_beat);
    out_enq_v    = empty ? in_enq_v : mem[rd_ptr[aw-1:0]];
    rd_mem       = out_enq__ENA & ~empty;
    wr_mem       = push & ~(byp_beat & out_enq__RDY);
    count        = wr_ptr - rd_ptr;
    almost_full  = (count >= afull_c);
  end

  // Pointer registers; reset discards every stored beat.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_mem) wr_ptr <= wr_ptr + ptr_one;
      if (rd_mem) rd_ptr <= rd_ptr + ptr_one;
    end
  end

  // Storage array, intentionally not reset.
  always_ff @(posedge CLK) begin
    if (wr_mem) mem[wr_ptr[aw-1:0]] <= in_enq_v;
  end

endmodule

// File: tb/tb_fifo_p_depth.sv
// Bench for fifo_p_depth: one instance without bypass, one with bypass, each
// checked every cycle against a queue model, plus directed literal checks.
module tb_fifo_p_depth;

  localparam int W = 8;
  localparam int D = 4;
  localparam int AF = 3;

  logic CLK = 1'b0;
  logic nRST = 1'b0;

  logic         ena0 = 1'b0, ordy0 = 1'b0;
  logic [W-1:0] v0 = '0;
  logic         irdy0, oena0, af0;
  logic [W-1:0] ov0;
  logic [2:0]   cnt0;

  logic         ena1 = 1'b0, ordy1 = 1'b0;
  logic [W-1:0] v1 = '0;
  logic         irdy1, oena1, af1;
  logic [W-1:0] ov1;
  logic [2:0]   cnt1;

  int n_checks = 0;
  int n_pass = 0;

  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  bit p0, p1;

  fifo_p_depth #(.width(W), .depth(D), .afull(AF), .bypass(0)) u0 (
    .CLK(CLK), .nRST(nRST),
    .in_enq__ENA(ena0), .in_enq_v(v0), .in_enq__RDY(irdy0),
    .out_enq__ENA(oena0), .out_enq_v(ov0), .out_enq__RDY(ordy0),
    .count(cnt0), .almost_full(af0));

  fifo_p_depth #(.width(W), .depth(D), .afull(AF), .bypass(1)) u1 (
    .CLK(CLK), .nRST(nRST),
    .in_enq__ENA(ena1), .in_enq_v(v1), .in_enq__RDY(irdy1),
    .out_enq__ENA(oena1), .out_enq_v(ov1), .out_enq__RDY(ordy1),
    .count(cnt1), .almost_full(af1));

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
  endtask

  // Expected outputs of one instance from model occupancy and current inputs.
  task automatic check_one(input string nm, input bit bp, input int sz, input logic [W-1:0] head,
                           input logic ena, input logic [W-1:0] v, input logic ordy,
                           input logic irdy, input logic oena, input logic [W-1:0] ov,
                           input logic [2:0] cnt, input logic af);
    logic e_rdy, e_push, e_oena;
    e_rdy  = nRST && (sz < D);
    e_push = ena && e_rdy;
    e_oena = ordy && nRST && ((sz > 0) || (bp && e_push));
    chk({nm, "_rdy"}, irdy, e_rdy);
    chk({nm, "_oena"}, oena, e_oena);
    chk({nm, "_cnt"}, cnt, sz);
    chk({nm, "_af"}, af, sz >= AF);
    if (e_oena) chk({nm, "_ov"}, ov, (sz > 0) ? head : v);
    if (nRST) chk({nm, "_proto"}, ena && !irdy, 1'b0);
  endtask

  // Per-cycle comparison against the queue models.
  always @(negedge CLK) begin
    check_one("m0", 1'b0, q0.size(), (q0.size() > 0) ? q0[0] : '0,
              ena0, v0, ordy0, irdy0, oena0, ov0, cnt0, af0);
    check_one("m1", 1'b1, q1.size(), (q1.size() > 0) ? q1[0] : '0,
              ena1, v1, ordy1, irdy1, oena1, ov1, cnt1, af1);
  end

  // Queue models advance on each clock edge; reset empties them at once.
  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      q0.delete();
      q1.delete();
    end else begin
      p0 = ena0 && (q0.size() < D);
      if (ordy0 && q0.size() > 0) void'(q0.pop_front());
      if (p0) q0.push_back(v0);
      p1 = ena1 && (q1.size() < D);
      if (!(q1.size() == 0 && p1 && ordy1)) begin
        if (ordy1 && q1.size() > 0) void'(q1.pop_front());
        if (p1) q1.push_back(v1);
      end
    end
  end

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // Reset held with enq strobe active.
    ena0 = 1'b1; v0 = 8'h11;
    repeat (3) begin
      @(negedge CLK);
      chk("rst_rdy", irdy0, 1'b0);
      chk("rst_oena", oena0, 1'b0);
      chk("rst_cnt", cnt0, 3'd0);
    end
    next_cycle();
    ena0 = 1'b0;
    nRST = 1'b1;
    @(negedge CLK);
    chk("rel_rdy", irdy0, 1'b1);
    next_cycle();

    // Fill with downstream stalled.
    ordy0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ena0 = 1'b1; v0 = 8'hA1 + 8'(i);
      @(negedge CLK);
      chk("fill_cnt", cnt0, i);
      chk("fill_af", af0, i >= 3);
      next_cycle();
    end
    ena0 = 1'b0;
    @(negedge CLK);
    chk("full_cnt", cnt0, 3'd4);
    chk("full_rdy", irdy0, 1'b0);
    chk("full_af", af0, 1'b1);
    next_cycle();

    // Drain in order.
    ordy0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("drain_oena", oena0, 1'b1);
      chk("drain_v", ov0, 8'hA1 + 8'(i));
      chk("drain_cnt", cnt0, 4 - i);
      chk("drain_rdy", irdy0, i > 0);
      next_cycle();
    end
    @(negedge CLK);
    chk("empty_oena", oena0, 1'b0);
    chk("empty_cnt", cnt0, 3'd0);
    next_cycle();

    // Full, pop one, then continuous push+pop across pointer wrap.
    ordy0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ena0 = 1'b1; v0 = 8'hB0 + 8'(i);
      next_cycle();
    end
    ena0 = 1'b0; ordy0 = 1'b1;
    next_cycle();
    for (int k = 0; k < 20; k++) begin
      ena0 = 1'b1; v0 = 8'hC0 + 8'(k); ordy0 = 1'b1;
      @(negedge CLK);
      chk("pp_cnt", cnt0, 3'd3);
      chk("pp_v", ov0, (k < 3) ? 8'hB1 + 8'(k) : 8'hC0 + 8'(k - 3));
      next_cycle();
    end
    ena0 = 1'b0;
    repeat (4) next_cycle();

    // Bypass instance: same-cycle forward, then stalled forward.
    ena1 = 1'b1; v1 = 8'h55; ordy1 = 1'b1;
    @(negedge CLK);
    chk("byp_oena", oena1, 1'b1);
    chk("byp_v", ov1, 8'h55);
    chk("byp_cnt", cnt1, 3'd0);
    next_cycle();
    ena1 = 1'b0;
    @(negedge CLK);
    chk("byp_cnt_after", cnt1, 3'd0);
    chk("byp_oena_after", oena1, 1'b0);
    next_cycle();
    ena1 = 1'b1; v1 = 8'h55; ordy1 = 1'b0;
    @(negedge CLK);
    chk("bst_oena", oena1, 1'b0);
    next_cycle();
    ena1 = 1'b0; ordy1 = 1'b1;
    @(negedge CLK);
    chk("bst_cnt", cnt1, 3'd1);
    chk("bst_oena2", oena1, 1'b1);
    chk("bst_v", ov1, 8'h55);
    next_cycle();

    // Random traffic on both instances.
    for (int n = 0; n < 3000; n++) begin
      ena0  = ($urandom_range(0, 3) != 0) && (q0.size() < D);
      v0    = 8'($urandom);
      ordy0 = ($urandom_range(0, 2) != 0);
      ena1  = ($urandom_range(0, 2) != 0) && (q1.size() < D);
      v1    = 8'($urandom);
      ordy1 = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
      next_cycle();
    end
    ena0 = 1'b0; ena1 = 1'b0; ordy0 = 1'b1; ordy1 = 1'b1;
    repeat (6) next_cycle();

    // Async reset mid-stream.
    ordy0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ena0 = 1'b1; v0 = 8'hD0 + 8'(i);
      next_cycle();
    end
    ena0 = 1'b0; ordy0 = 1'b1;
    #1;
    chk("mid_cnt_pre", cnt0, 3'd3);
    #1;
    nRST = 1'b0;
    #1;
    chk("mid_cnt", cnt0, 3'd0);
    chk("mid_oena", oena0, 1'b0);
    repeat (2) @(posedge CLK);
    #2;
    nRST = 1'b1;
    ordy0 = 1'b0;
    next_cycle();
    ena0 = 1'b1; v0 = 8'h77;
    next_cycle();
    ena0 = 1'b0; ordy0 = 1'b1;
    @(negedge CLK);
    chk("post_oena", oena0, 1'b1);
    chk("post_v", ov0, 8'h77);
    chk("post_cnt", cnt0, 3'd1);
    next_cycle();
    ordy0 = 1'b0;
    repeat (2) next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
